pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- id_rs1_i, id_rs2_i  in  5 each  source registers of the instruction in ID.
- ex_rs1_i, ex_rs2_i  in  5 each  source registers of the instruction in EX.
- ex_rd_i, ex_reg_write_i, ex_mem_read_i  in  5/1/1  EX destination, write enable, load flag.
- mem_rd_i, mem_reg_write_i  in  5/1  MEM-stage destination and write enable.
- wb_rd_i, wb_reg_write_i  in  5/1  WB-stage destination and write enable.
- ex_branch_taken_i  in  1  EX resolved a taken branch/jump.
- ex_trap_i  in  1  EX holds a syscall or break.
- dmem_req_i, dmem_ready_i  in  1/1  MEM-stage data access pending / completed.
- trap_ack_i  in  1  trap handler accepted the trap.
- if_stall_o, id_stall_o, ex_stall_o, mem_stall_o  out  1 each  hold stage register.
- if_flush_o, id_flush_o, ex_flush_o  out  1 each  replace stage register with bubble.
- fwd_a_sel_o, fwd_b_sel_o  out  2 each  EX operand source: 00 regfile, 01 MEM result, 10 WB result.
- trap_req_o  out  1  trap request to handler.

Function
REQ-002 SHALL implement FSM states RUN, MEM_WAIT, DRAIN, TRAP; outputs combinational from state and inputs.
REQ-003 Forwarding (all states): fwd_a_sel_o=01 if mem_reg_write_i && mem_rd_i!=0 && mem_rd_i==ex_rs1_i; else 10 if wb_reg_write_i && wb_rd_i!=0 && wb_rd_i==ex_rs1_i; else 00. fwd_b_sel_o uses ex_rs2_i the same way. MEM match has priority over WB.
REQ-004 Load-use, in RUN: ex_mem_read_i && ex_rd_i!=0 && ex_rd_i==(id_rs1_i or id_rs2_i) SHALL assert if_stall_o, id_stall_o, ex_flush_o for exactly that cycle (one bubble).
REQ-005 Branch, in RUN: ex_branch_taken_i SHALL assert if_flush_o and id_flush_o for one cycle. When branch and load-use coincide, the branch wins and no load-use stall occurs.
REQ-006 In RUN or DRAIN, dmem_req_i && !dmem_ready_i SHALL enter MEM_WAIT the same cycle (combinational hold). MEM_WAIT asserts all four stall outputs and suppresses every flush. Exit on dmem_ready_i back to the originating state, with the state and drain counter preserved.
REQ-007 Memory wait priority: MEM_WAIT > trap > branch > load-use. A branch or trap held in EX during MEM_WAIT SHALL be acted on in the cycle dmem_ready_i is high.
REQ-008 RUN with ex_trap_i (and no memory wait):
- asserts if_flush_o, id_flush_o and if_stall_o;
- loads a 2-bit drain counter with 2;
- moves to DRAIN.
REQ-009 DRAIN:
- asserts if_stall_o, id_flush_o and ex_flush_o;
- decrements the counter each non-waiting cycle;
- at counter==0 moves to TRAP.
REQ-010 TRAP:
- asserts trap_req_o, if_stall_o, id_flush_o, ex_flush_o;
- stays until trap_ack_i;
- on trap_ack_i: next state RUN, if_flush_o=1 for that cycle, trap_req_o drops the next cycle.
REQ-011 In DRAIN and TRAP, ex_trap_i, ex_branch_taken_i and load-use SHALL be ignored.
REQ-012 trap_ack_i outside TRAP SHALL have no effect.

Reset
REQ-013 rst_i high at a clock edge SHALL set state=RUN and drain counter=0, overriding any in-progress wait or trap.
REQ-014 While rst_i is high:
- all stalls 0;
- if_flush_o, id_flush_o, ex_flush_o = 1;
- trap_req_o = 0;
- fwd selects 00.
REQ-015 First cycle after reset deassertion SHALL behave as RUN, with all flush outputs 0 absent other stimulus.

Verification
REQ-016 Bench SHALL cover:
- Forwarding: ex_rs1=5, mem_rd=5/mem_reg_write=1, wb_rd=5/wb_reg_write=1 -> fwd_a_sel=01. Then mem_reg_write=0 -> 10. Then rd=0 everywhere -> 00.
- Load-use: ex_mem_read=1, ex_rd=15, id_rs2=15 -> if_stall=id_stall=ex_flush=1 for one cycle. Adding ex_branch_taken=1 -> only if_flush=id_flush=1.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles with ex_branch_taken=1 -> all stalls 1 and no flush for 3 cycles. dmem_ready=1 -> if_flush=id_flush=1.
- Trap: ex_trap=1 in RUN -> DRAIN for 2 cycles, then trap_req=1 held 4 cycles. trap_ack=1 -> if_flush=1, trap_req=0 next cycle, state RUN.
- Memory wait inside DRAIN: counter frozen for the 2 wait cycles, so TRAP is reached 2 cycles later than REQ-009 alone gives.
- Reset: rst_i=1 while in TRAP with trap_req=1 -> next cycle trap_req=0, all flushes 1. After deassertion, state RUN.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and control unit for a five-stage in-order pipeline.
//
// Purpose: generates per-stage stall and flush controls, selects EX operand
// forwarding sources, and sequences trap entry (drain the pipe, then raise a
// trap request and hold it until the handler acknowledges).
//
// Ports:
//   clk_i, rst_i                    clock; synchronous active-high reset
//   id_rs1_i, id_rs2_i              ID-stage source registers
//   ex_rs1_i, ex_rs2_i              EX-stage source registers
//   ex_rd_i, ex_reg_write_i,
//   ex_mem_read_i                   EX destination, write enable, load flag
//   mem_rd_i, mem_reg_write_i       MEM destination and write enable
//   wb_rd_i, wb_reg_write_i         WB destination and write enable
//   ex_branch_taken_i               EX resolved a taken branch/jump
//   ex_trap_i                       EX holds a syscall/break
//   dmem_req_i, dmem_ready_i        MEM data access pending / completed
//   trap_ack_i                      trap handler accepted the trap
//   if/id/ex/mem_stall_o            hold the stage register
//   if/id/ex_flush_o                replace the stage register with a bubble
//   fwd_a_sel_o, fwd_b_sel_o        00 regfile, 01 MEM result, 10 WB result
//   trap_req_o                      trap request to the handler
module pipeline_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic [4:0] ex_rs1_i,
    input  logic [4:0] ex_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_reg_write_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_reg_write_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_reg_write_i,
    input  logic       ex_branch_taken_i,
    input  logic       ex_trap_i,
    input  logic       dmem_req_i,
    input  logic       dmem_ready_i,
    input  logic       trap_ack_i,
    output logic       if_stall_o,
    output logic       id_stall_o,
    output logic       ex_stall_o,
    output logic       mem_stall_o,
    output logic       if_flush_o,
    output logic       id_flush_o,
    output logic       ex_flush_o,
    output logic [1:0] fwd_a_sel_o,
    output logic [1:0] fwd_b_sel_o,
    output logic       trap_req_o
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StDrain   = 2'd2,
        StTrap    = 2'd3
    } state_e;

    state_e     state_q, state_d;
    state_e     ret_q, ret_d;     // state to resume when the memory wait ends
    state_e     eff_state;        // state whose behaviour applies this cycle
    logic [1:0] cnt_q, cnt_d;     // drain counter
    logic       load_use;

    // ex_reg_write_i is not needed: a load always writes its destination.
    logic unused_ex_reg_write;
    assign unused_ex_reg_write = ex_reg_write_i;

    assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                      ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StRun;
            ret_q   <= StRun;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    // Forwarding: MEM result is younger than WB, so it takes priority.
    always_comb begin
        fwd_a_sel_o = 2'b00;
        fwd_b_sel_o = 2'b00;
        if (mem_reg_write_i && mem_rd_i != 5'd0 && mem_rd_i == ex_rs1_i) begin
            fwd_a_sel_o = 2'b01;
        end else if (wb_reg_write_i && wb_rd_i != 5'd0 && wb_rd_i == ex_rs1_i) begin
            fwd_a_sel_o = 2'b10;
        end
        if (mem_reg_write_i && mem_rd_i != 5'd0 && mem_rd_i == ex_rs2_i) begin
            fwd_b_sel_o = 2'b01;
        end else if (wb_reg_write_i && wb_rd_i != 5'd0 && wb_rd_i == ex_rs2_i) begin
            fwd_b_sel_o = 2'b10;
        end
        if (rst_i) begin
            fwd_a_sel_o = 2'b00;
            fwd_b_sel_o = 2'b00;
        end
    end

    always_comb begin
        if_stall_o  = 1'b0;
        id_stall_o  = 1'b0;
        ex_stall_o  = 1'b0;
        mem_stall_o = 1'b0;
        if_flush_o  = 1'b0;
        id_flush_o  = 1'b0;
        ex_flush_o  = 1'b0;
        trap_req_o  = 1'b0;
        state_d     = state_q;
        ret_d       = ret_q;
        cnt_d       = cnt_q;

        // A completed access resumes the originating state in the same cycle,
        // so a branch or trap held in EX is acted on right away.
        eff_state = state_q;
        if (state_q == StMemWait && dmem_ready_i) begin
            eff_state = ret_q;
        end
        // Entering the wait is combinational: hold the pipe this very cycle.
        if ((eff_state == StRun || eff_state == StDrain) && dmem_req_i && !dmem_ready_i) begin
            eff_state = StMemWait;
        end

        case (eff_state)
            StMemWait: begin
                if_stall_o  = 1'b1;
                id_stall_o  = 1'b1;
                ex_stall_o  = 1'b1;
                mem_stall_o = 1'b1;
                state_d     = StMemWait;
                if (state_q != StMemWait) begin
                    ret_d = state_q;
                end
            end
            StRun: begin
                state_d = StRun;
                if (ex_trap_i) begin
                    if_flush_o = 1'b1;
                    id_flush_o = 1'b1;
                    if_stall_o = 1'b1;
                    cnt_d      = 2'd2;
                    state_d    = StDrain;
                end else if (ex_branch_taken_i) begin
                    if_flush_o = 1'b1;
                    id_flush_o = 1'b1;
                end else if (load_use) begin
                    if_stall_o = 1'b1;
                    id_stall_o = 1'b1;
                    ex_flush_o = 1'b1;
                end
            end
            StDrain: begin
                if_stall_o = 1'b1;
                id_flush_o = 1'b1;
                ex_flush_o = 1'b1;
                state_d    = StDrain;
                // Leave on the cycle the counter reaches zero.
                if (cnt_q <= 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = StTrap;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StTrap: begin
                trap_req_o = 1'b1;
                if_stall_o = 1'b1;
                id_flush_o = 1'b1;
                ex_flush_o = 1'b1;
                state_d    = StTrap;
                if (trap_ack_i) begin
                    if_flush_o = 1'b1;
                    state_d    = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (rst_i) begin
            if_stall_o  = 1'b0;
            id_stall_o  = 1'b0;
            ex_stall_o  = 1'b0;
            mem_stall_o = 1'b0;
            if_flush_o  = 1'b1;
            id_flush_o  = 1'b1;
            ex_flush_o  = 1'b1;
            trap_req_o  = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs1_i, id_rs2_i, ex_rs1_i, ex_rs2_i, ex_rd_i, mem_rd_i, wb_rd_i;
    logic       ex_reg_write_i, ex_mem_read_i, mem_reg_write_i, wb_reg_write_i;
    logic       ex_branch_taken_i, ex_trap_i, dmem_req_i, dmem_ready_i, trap_ack_i;
    logic       if_stall_o, id_stall_o, ex_stall_o, mem_stall_o;
    logic       if_flush_o, id_flush_o, ex_flush_o, trap_req_o;
    logic [1:0] fwd_a_sel_o, fwd_b_sel_o;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .id_rs1_i          (id_rs1_i),
        .id_rs2_i          (id_rs2_i),
        .ex_rs1_i          (ex_rs1_i),
        .ex_rs2_i          (ex_rs2_i),
        .ex_rd_i           (ex_rd_i),
        .ex_reg_write_i    (ex_reg_write_i),
        .ex_mem_read_i     (ex_mem_read_i),
        .mem_rd_i          (mem_rd_i),
        .mem_reg_write_i   (mem_reg_write_i),
        .wb_rd_i           (wb_rd_i),
        .wb_reg_write_i    (wb_reg_write_i),
        .ex_branch_taken_i (ex_branch_taken_i),
        .ex_trap_i         (ex_trap_i),
        .dmem_req_i        (dmem_req_i),
        .dmem_ready_i      (dmem_ready_i),
        .trap_ack_i        (trap_ack_i),
        .if_stall_o        (if_stall_o),
        .id_stall_o        (id_stall_o),
        .ex_stall_o        (ex_stall_o),
        .mem_stall_o       (mem_stall_o),
        .if_flush_o        (if_flush_o),
        .id_flush_o        (id_flush_o),
        .ex_flush_o        (ex_flush_o),
        .fwd_a_sel_o       (fwd_a_sel_o),
        .fwd_b_sel_o       (fwd_b_sel_o),
        .trap_req_o        (trap_req_o)
    );

    // Control outputs packed as {if_stall, id_stall, ex_stall, mem_stall,
    //                            if_flush, id_flush, ex_flush, trap_req}.
    localparam logic [7:0] Quiet  = 8'b0000_0000;
    localparam logic [7:0] RstOut = 8'b0000_1110;
    localparam logic [7:0] LdUse  = 8'b1100_0010;
    localparam logic [7:0] Branch = 8'b0000_1100;
    localparam logic [7:0] Wait   = 8'b1111_0000;
    localparam logic [7:0] TrapIn = 8'b1000_1100;
    localparam logic [7:0] Drain  = 8'b1000_0110;
    localparam logic [7:0] Trap   = 8'b1000_0111;
    localparam logic [7:0] TrapAk = 8'b1000_1111;

    function automatic logic [7:0] outs();
        return {if_stall_o, id_stall_o, ex_stall_o, mem_stall_o,
                if_flush_o, id_flush_o, ex_flush_o, trap_req_o};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Let inputs settle, then move past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear();
        id_rs1_i = 0; id_rs2_i = 0; ex_rs1_i = 0; ex_rs2_i = 0; ex_rd_i = 0;
        mem_rd_i = 0; wb_rd_i = 0;
        ex_reg_write_i = 0; ex_mem_read_i = 0; mem_reg_write_i = 0; wb_reg_write_i = 0;
        ex_branch_taken_i = 0; ex_trap_i = 0; dmem_req_i = 0; dmem_ready_i = 0;
        trap_ack_i = 0;
    endtask

    initial begin
        clear();
        rst_i = 1'b1;
        // Forwarding-matching inputs must still read 00 under reset.
        ex_rs1_i = 5; mem_rd_i = 5; mem_reg_write_i = 1;
        tick();
        #1 chk("reset_outs", outs(), RstOut);
        chk("reset_fwd_a", {6'd0, fwd_a_sel_o}, 8'd0);

        rst_i = 1'b0;
        clear();
        #1 chk("post_reset_quiet", outs(), Quiet);

        // Forwarding.
        ex_rs1_i = 5; mem_rd_i = 5; mem_reg_write_i = 1; wb_rd_i = 5; wb_reg_write_i = 1;
        #1 chk("fwd_a_mem", {6'd0, fwd_a_sel_o}, 8'd1);
        chk("fwd_b_none", {6'd0, fwd_b_sel_o}, 8'd0);
        ex_rs2_i = 5;
        #1 chk("fwd_b_mem", {6'd0, fwd_b_sel_o}, 8'd1);
        mem_reg_write_i = 0;
        #1 chk("fwd_a_wb", {6'd0, fwd_a_sel_o}, 8'd2);
        chk("fwd_b_wb", {6'd0, fwd_b_sel_o}, 8'd2);
        ex_rs1_i = 0; ex_rs2_i = 0; mem_rd_i = 0; wb_rd_i = 0; mem_reg_write_i = 1;
        #1 chk("fwd_a_r0", {6'd0, fwd_a_sel_o}, 8'd0);
        chk("fwd_outs_quiet", outs(), Quiet);
        clear();

        // Load-use.
        ex_mem_read_i = 1; ex_rd_i = 15; id_rs2_i = 15; ex_reg_write_i = 1;
        #1 chk("load_use", outs(), LdUse);
        tick();
        clear();
        #1 chk("load_use_one_cycle", outs(), Quiet);
        ex_mem_read_i = 1; ex_rd_i = 15; id_rs2_i = 15; ex_branch_taken_i = 1;
        #1 chk("branch_beats_load_use", outs(), Branch);
        tick();
        clear();
        trap_ack_i = 1;
        #1 chk("ack_in_run_ignored", outs(), Quiet);
        tick();
        clear();

        // Memory wait with a pending branch.
        dmem_req_i = 1; dmem_ready_i = 0; ex_branch_taken_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("mem_wait_%0d", i), outs(), Wait);
            tick();
        end
        dmem_ready_i = 1;
        #1 chk("mem_wait_release_branch", outs(), Branch);
        tick();
        clear();
        #1 chk("mem_wait_back_run", outs(), Quiet);

        // Trap sequence; trap/branch held in EX must be ignored while draining.
        ex_trap_i = 1;
        #1 chk("trap_enter", outs(), TrapIn);
        tick();
        ex_branch_taken_i = 1;
        for (int i = 0; i < 2; i++) begin
            #1 chk($sformatf("drain_%0d", i), outs(), Drain);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("trap_hold_%0d", i), outs(), Trap);
            tick();
        end
        clear();
        trap_ack_i = 1;
        #1 chk("trap_ack", outs(), TrapAk);
        tick();
        clear();
        #1 chk("trap_req_drops", outs(), Quiet);
        ex_branch_taken_i = 1;
        #1 chk("after_trap_run", outs(), Branch);
        tick();
        clear();

        // Memory wait inside DRAIN freezes the counter.
        ex_trap_i = 1;
        tick();
        clear();
        #1 chk("drain_w_0", outs(), Drain);
        tick();
        dmem_req_i = 1; dmem_ready_i = 0;
        for (int i = 0; i < 2; i++) begin
            #1 chk($sformatf("drain_wait_%0d", i), outs(), Wait);
            tick();
        end
        dmem_ready_i = 1;
        #1 chk("drain_w_1", outs(), Drain);
        tick();
        clear();
        #1 chk("drain_w_trap", outs(), Trap);

        // Reset while in TRAP.
        rst_i = 1;
        #1 chk("rst_in_trap_now", outs(), RstOut);
        tick();
        #1 chk("rst_in_trap_next", outs(), RstOut);
        rst_i = 0;
        #1 chk("after_rst_quiet", outs(), Quiet);
        ex_branch_taken_i = 1;
        #1 chk("after_rst_run", outs(), Branch);
        tick();
        clear();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
